// File: rtl/ieeedrv_sector_rd.sv
// ieeedrv_sector_rd
//   Read-side sector framer. Watches the byte stream coming from the track
//   generator, hunts for the header of the requested track/sector, checks
//   it, then copies the 256-byte data block into a controller buffer and
//   verifies the data checksum. The result is reported as a 3-bit status
//   code with a one-cycle done pulse.
//
// Ports
//   clk_sys, reset          clock, synchronous active-high reset
//   req, abort              start pulse (ignored while busy) / abort pulse
//   req_track, req_sector,
//   req_id, check_id        request fields, latched on req
//   sync_n, brdy_n, byte_in generator stream (sync low, byte-ready low pulse)
//   busy, done, status      request in progress / completion pulse / result
//                           0 OK, 1 no header, 2 no sync, 3 no data block,
//                           4 data checksum, 5 header checksum,
//                           6 ID mismatch, 7 aborted
//   buf_addr, buf_data,
//   buf_we                  data buffer write port
//   hdr_sector, hdr_id      fields of the last parsed header
//
// Handshake: a byte is taken once per falling edge of brdy_n (stb). Buffer
// writes are single-cycle strobes with buf_addr/buf_data valid while buf_we
// is high; buf_addr advances in the cycle after each write.
module ieeedrv_sector_rd #(
   parameter int MAX_HDRS     = 64,
   parameter int NOSYNC_BYTES = 1024,
   parameter int DATA_WIN     = 64
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        req,
   input  logic        abort,
   input  logic [7:0]  req_track,
   input  logic [4:0]  req_sector,
   input  logic [15:0] req_id,
   input  logic        check_id,
   input  logic        sync_n,
   input  logic        brdy_n,
   input  logic [7:0]  byte_in,
   output logic        busy,
   output logic        done,
   output logic [2:0]  status,
   output logic [7:0]  buf_addr,
   output logic [7:0]  buf_data,
   output logic        buf_we,
   output logic [4:0]  hdr_sector,
   output logic [15:0] hdr_id
);

   localparam int HW = $clog2(MAX_HDRS + 1);
   localparam int NW = $clog2(NOSYNC_BYTES + 1);
   localparam int WW = $clog2(DATA_WIN + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_HUNT_HDR, S_HDR, S_HUNT_DATA, S_DATA, S_CHK
   } state_t;

   state_t        state, state_d;
   logic          brdy_l, sync_seen, sync_seen_d;
   logic          busy_d, done_d, buf_we_d;
   logic [2:0]    status_d;
   logic [7:0]    buf_addr_d, buf_data_d;
   logic [4:0]    hdr_sector_d;
   logic [15:0]   hdr_id_d;
   logic [7:0]    r_track, r_track_d;
   logic [4:0]    r_sector, r_sector_d;
   logic [15:0]   r_id, r_id_d;
   logic          r_check, r_check_d;
   logic [2:0]    byte_idx, byte_idx_d;
   logic [7:0]    h_chk, h_chk_d, h_sec, h_sec_d, h_trk, h_trk_d, h_idh, h_idh_d;
   logic [HW-1:0] hdr_cnt, hdr_cnt_d, hdr_cnt_inc;
   logic [WW-1:0] win_cnt, win_cnt_d, win_cnt_inc;
   logic [NW-1:0] nosync_cnt, nosync_cnt_d, nosync_inc;
   logic [7:0]    xor_acc, xor_acc_d;
   logic          stb, code, fin;
   logic [2:0]    fin_code;

   assign stb         = brdy_l & ~brdy_n;
   // A block code is the first non-sync byte after a sync mark.
   assign code        = stb & sync_n & sync_seen;
   assign hdr_cnt_inc = hdr_cnt + 1'b1;
   assign win_cnt_inc = win_cnt + 1'b1;
   assign nosync_inc  = nosync_cnt + 1'b1;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state      <= S_IDLE;
         brdy_l     <= 1'b1;
         sync_seen  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         status     <= 3'd0;
         buf_addr   <= 8'd0;
         buf_data   <= 8'd0;
         buf_we     <= 1'b0;
         hdr_sector <= 5'd0;
         hdr_id     <= 16'd0;
         r_track    <= 8'd0;
         r_sector   <= 5'd0;
         r_id       <= 16'd0;
         r_check    <= 1'b0;
         byte_idx   <= 3'd0;
         h_chk      <= 8'd0;
         h_sec      <= 8'd0;
         h_trk      <= 8'd0;
         h_idh      <= 8'd0;
         hdr_cnt    <= '0;
         win_cnt    <= '0;
         nosync_cnt <= '0;
         xor_acc    <= 8'd0;
      end else begin
         state      <= state_d;
         brdy_l     <= brdy_n;
         sync_seen  <= sync_seen_d;
         busy       <= busy_d;
         done       <= done_d;
         status     <= status_d;
         buf_addr   <= buf_addr_d;
         buf_data   <= buf_data_d;
         buf_we     <= buf_we_d;
         hdr_sector <= hdr_sector_d;
         hdr_id     <= hdr_id_d;
         r_track    <= r_track_d;
         r_sector   <= r_sector_d;
         r_id       <= r_id_d;
         r_check    <= r_check_d;
         byte_idx   <= byte_idx_d;
         h_chk      <= h_chk_d;
         h_sec      <= h_sec_d;
         h_trk      <= h_trk_d;
         h_idh      <= h_idh_d;
         hdr_cnt    <= hdr_cnt_d;
         win_cnt    <= win_cnt_d;
         nosync_cnt <= nosync_cnt_d;
         xor_acc    <= xor_acc_d;
      end
   end

   always_comb begin
      state_d      = state;
      busy_d       = busy;
      done_d       = 1'b0;
      status_d     = status;
      buf_we_d     = 1'b0;
      buf_data_d   = buf_data;
      // The address of a write holds through its strobe, then advances.
      buf_addr_d   = buf_we ? buf_addr + 8'd1 : buf_addr;
      hdr_sector_d = hdr_sector;
      hdr_id_d     = hdr_id;
      r_track_d    = r_track;
      r_sector_d   = r_sector;
      r_id_d       = r_id;
      r_check_d    = r_check;
      byte_idx_d   = byte_idx;
      h_chk_d      = h_chk;
      h_sec_d      = h_sec;
      h_trk_d      = h_trk;
      h_idh_d      = h_idh;
      hdr_cnt_d    = hdr_cnt;
      win_cnt_d    = win_cnt;
      nosync_cnt_d = nosync_cnt;
      xor_acc_d    = xor_acc;
      fin          = 1'b0;
      fin_code     = 3'd0;
      if (!sync_n)
         sync_seen_d = 1'b1;
      else if (stb)
         sync_seen_d = 1'b0;
      else
         sync_seen_d = sync_seen;

      if (state == S_IDLE) begin
         // done high means the previous request just finished: drop req.
         if (req && !done) begin
            r_track_d    = req_track;
            r_sector_d   = req_sector;
            r_id_d       = req_id;
            r_check_d    = check_id;
            status_d     = 3'd0;
            hdr_cnt_d    = '0;
            win_cnt_d    = '0;
            nosync_cnt_d = '0;
            busy_d       = 1'b1;
            state_d      = S_HUNT_HDR;
         end
      end else if (abort) begin
         fin      = 1'b1;
         fin_code = 3'd7;
      end else begin
         // No-sync watchdog, active only while hunting.
         if (state == S_HUNT_HDR || state == S_HUNT_DATA) begin
            if (!sync_n)
               nosync_cnt_d = '0;
            else if (stb && !sync_seen) begin
               if (nosync_inc == NW'(NOSYNC_BYTES)) begin
                  fin      = 1'b1;
                  fin_code = 3'd2;
               end else
                  nosync_cnt_d = nosync_inc;
            end
         end
         case (state)
            S_HUNT_HDR: begin
               if (code && byte_in == 8'h08) begin
                  state_d    = S_HDR;
                  byte_idx_d = 3'd0;
               end
            end
            S_HDR: begin
               if (!sync_n)
                  state_d = S_HUNT_HDR;
               else if (stb) begin
                  byte_idx_d = byte_idx + 3'd1;
                  case (byte_idx)
                     3'd0: h_chk_d = byte_in;
                     3'd1: begin
                        h_sec_d      = byte_in;
                        hdr_sector_d = byte_in[4:0];
                     end
                     3'd2: h_trk_d = byte_in;
                     3'd3: begin
                        h_idh_d        = byte_in;
                        hdr_id_d[15:8] = byte_in;
                     end
                     default: begin
                        hdr_id_d[7:0] = byte_in;
                        hdr_cnt_d     = hdr_cnt_inc;
                        // A matching header wins over the header limit.
                        if (h_sec != {3'd0, r_sector} || h_trk != r_track) begin
                           state_d = S_HUNT_HDR;
                           if (hdr_cnt_inc == HW'(MAX_HDRS)) begin
                              fin      = 1'b1;
                              fin_code = 3'd1;
                           end
                        end else if (h_chk != (h_sec ^ h_trk ^ h_idh ^ byte_in)) begin
                           fin      = 1'b1;
                           fin_code = 3'd5;
                        end else if (r_check && {h_idh, byte_in} != r_id) begin
                           fin      = 1'b1;
                           fin_code = 3'd6;
                        end else begin
                           state_d   = S_HUNT_DATA;
                           win_cnt_d = '0;
                        end
                     end
                  endcase
               end
            end
            S_HUNT_DATA: begin
               if (stb) begin
                  win_cnt_d = win_cnt_inc;
                  if (code && byte_in == 8'h07) begin
                     state_d    = S_DATA;
                     buf_addr_d = 8'd0;
                     xor_acc_d  = 8'd0;
                  end else if (code || win_cnt_inc == WW'(DATA_WIN)) begin
                     fin      = 1'b1;
                     fin_code = 3'd3;
                  end
               end
            end
            S_DATA: begin
               if (!sync_n) begin
                  fin      = 1'b1;
                  fin_code = 3'd3;
               end else if (stb) begin
                  buf_we_d   = 1'b1;
                  buf_data_d = byte_in;
                  xor_acc_d  = xor_acc ^ byte_in;
                  if (buf_addr == 8'hff)
                     state_d = S_CHK;
               end
            end
            S_CHK: begin
               if (!sync_n) begin
                  fin      = 1'b1;
                  fin_code = 3'd3;
               end else if (stb) begin
                  fin      = 1'b1;
                  fin_code = (byte_in == xor_acc) ? 3'd0 : 3'd4;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      if (fin) begin
         state_d  = S_IDLE;
         busy_d   = 1'b0;
         done_d   = 1'b1;
         status_d = fin_code;
      end
   end

endmodule

// File: tb/tb_ieeedrv_sector_rd.sv
module tb_ieeedrv_sector_rd;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        req = 1'b0;
   logic        abort = 1'b0;
   logic [7:0]  req_track = 8'd0;
   logic [4:0]  req_sector = 5'd0;
   logic [15:0] req_id = 16'd0;
   logic        check_id = 1'b0;
   logic        sync_n = 1'b1;
   logic        brdy_n = 1'b1;
   logic [7:0]  byte_in = 8'd0;
   logic        busy, done, buf_we;
   logic [2:0]  status;
   logic [7:0]  buf_addr, buf_data;
   logic [4:0]  hdr_sector;
   logic [15:0] hdr_id;

   int n_checks = 0;
   int n_fail = 0;
   int done_cnt = 0;
   int we_cnt = 0;
   logic [15:0] exp_q[$];

   ieeedrv_sector_rd dut (
      .clk_sys(clk_sys), .reset(reset), .req(req), .abort(abort),
      .req_track(req_track), .req_sector(req_sector), .req_id(req_id),
      .check_id(check_id), .sync_n(sync_n), .brdy_n(brdy_n),
      .byte_in(byte_in), .busy(busy), .done(done), .status(status),
      .buf_addr(buf_addr), .buf_data(buf_data), .buf_we(buf_we),
      .hdr_sector(hdr_sector), .hdr_id(hdr_id)
   );

   // clock / reset
   always #5 clk_sys = ~clk_sys;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // scoreboard: every buffer write must match the head of exp_q
   always @(negedge clk_sys) begin
      if (done) done_cnt++;
      if (buf_we) begin
         we_cnt++;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: addr %0h data %0h, expected no write", buf_addr, buf_data);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            if ({buf_addr, buf_data} !== e) begin
               n_fail++;
               $display("FAIL buf_write: got %0h, expected %0h", {buf_addr, buf_data}, e);
            end
         end
      end
   end

   // driver tasks
   task automatic tick;
      @(posedge clk_sys);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      byte_in = b;
      brdy_n = 1'b0;
      tick();
      tick();
      brdy_n = 1'b1;
      tick();
   endtask

   task automatic send_sync;
      sync_n = 1'b0;
      tick();
      tick();
      sync_n = 1'b1;
   endtask

   task automatic send_gap(input int n);
      for (int i = 0; i < n; i++) send_byte(8'h55);
   endtask

   task automatic send_header(input logic [7:0] sec, input logic [7:0] trk,
                              input logic [15:0] idv, input logic [7:0] flip);
      send_sync();
      send_byte(8'h08);
      send_byte(sec ^ trk ^ idv[15:8] ^ idv[7:0] ^ flip);
      send_byte(sec);
      send_byte(trk);
      send_byte(idv[15:8]);
      send_byte(idv[7:0]);
      send_gap(4);
   endtask

   // data bytes are i ^ base; the XOR of all 256 of them is 0
   task automatic send_data(input logic [7:0] base, input logic [7:0] flip);
      send_sync();
      send_byte(8'h07);
      for (int i = 0; i < 256; i++) send_byte(8'(i) ^ base);
      send_byte(8'h00 ^ flip);
      send_gap(4);
   endtask

   task automatic do_req(input logic [7:0] trk, input logic [4:0] sec,
                         input logic [15:0] idv, input logic chk);
      req_track = trk;
      req_sector = sec;
      req_id = idv;
      check_id = chk;
      req = 1'b1;
      tick();
      req = 1'b0;
   endtask

   typedef struct {
      logic        chk_id;
      logic [15:0] rid;
      logic [15:0] did;
      logic [7:0]  hdr_flip;
      logic [7:0]  dat_flip;
      logic [2:0]  exp_status;
      int          exp_writes;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int base;
      vecs[0] = '{1'b0, 16'h4142, 16'h4142, 8'h00, 8'h00, 3'd0, 256};
      vecs[1] = '{1'b0, 16'h4142, 16'h4142, 8'h01, 8'h00, 3'd5, 0};
      vecs[2] = '{1'b1, 16'h4142, 16'h4143, 8'h00, 8'h00, 3'd6, 0};
      vecs[3] = '{1'b0, 16'h4142, 16'h4143, 8'h00, 8'h00, 3'd0, 256};
      vecs[4] = '{1'b0, 16'h4142, 16'h4142, 8'h00, 8'hff, 3'd4, 256};
      vecs[5] = '{1'b1, 16'h4142, 16'h4142, 8'h00, 8'h00, 3'd0, 256};

      repeat (3) tick();
      reset = 1'b0;
      tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_status", status, 0);
      check("rst_buf_we", buf_we, 0);
      check("rst_buf_addr", buf_addr, 0);
      check("rst_buf_data", buf_data, 0);
      check("rst_hdr_sector", hdr_sector, 0);
      check("rst_hdr_id", hdr_id, 0);

      // table-driven requests: sector 2 (skipped) then sector 3
      for (int v = 0; v < 6; v++) begin
         base = done_cnt;
         we_cnt = 0;
         for (int i = 0; i < vecs[v].exp_writes; i++) exp_q.push_back({8'(i), 8'(i)});
         do_req(8'd1, 5'd3, vecs[v].rid, vecs[v].chk_id);
         check("req_busy", busy, 1);
         send_header(8'd2, 8'd1, vecs[v].did, 8'h00);
         send_data(8'ha5, 8'h00);
         send_header(8'd3, 8'd1, vecs[v].did, vecs[v].hdr_flip);
         send_data(8'h00, vecs[v].dat_flip);
         check("vec_done_cnt", done_cnt - base, 1);
         check("vec_status", status, vecs[v].exp_status);
         check("vec_writes", we_cnt, vecs[v].exp_writes);
         check("vec_busy", busy, 0);
         check("vec_hdr_sector", hdr_sector, 3);
         check("vec_hdr_id", hdr_id, vecs[v].did);
         check("vec_q_empty", exp_q.size(), 0);
      end

      // sector 30 never appears: give up after exactly 64 headers
      base = done_cnt;
      do_req(8'd1, 5'd30, 16'h4142, 1'b0);
      for (int h = 0; h < 63; h++) send_header(8'(h % 29), 8'd1, 16'h4142, 8'h00);
      check("hdr63_no_done", done_cnt - base, 0);
      check("hdr63_busy", busy, 1);
      send_header(8'(63 % 29), 8'd1, 16'h4142, 8'h00);
      check("hdr64_done", done_cnt - base, 1);
      check("hdr64_status", status, 1);

      // no sync at all for 1024 strobes
      base = done_cnt;
      do_req(8'd1, 5'd3, 16'h4142, 1'b0);
      send_gap(1023);
      check("nosync1023_busy", busy, 1);
      send_byte(8'h55);
      check("nosync_done", done_cnt - base, 1);
      check("nosync_status", status, 2);

      // data sync never arrives within the window
      base = done_cnt;
      do_req(8'd1, 5'd3, 16'h4142, 1'b0);
      send_header(8'd3, 8'd1, 16'h4142, 8'h00);
      send_gap(59);
      check("win63_busy", busy, 1);
      send_byte(8'h55);
      check("win_done", done_cnt - base, 1);
      check("win_status", status, 3);

      // sync in the middle of the data block
      base = done_cnt;
      we_cnt = 0;
      do_req(8'd1, 5'd3, 16'h4142, 1'b0);
      send_header(8'd3, 8'd1, 16'h4142, 8'h00);
      for (int i = 0; i < 10; i++) exp_q.push_back({8'(i), 8'(i)});
      send_sync();
      send_byte(8'h07);
      for (int i = 0; i < 10; i++) send_byte(8'(i));
      send_sync();
      check("trunc_done", done_cnt - base, 1);
      check("trunc_status", status, 3);
      check("trunc_writes", we_cnt, 10);
      send_gap(2);

      // abort after 100 data bytes
      base = done_cnt;
      do_req(8'd1, 5'd3, 16'h4142, 1'b0);
      send_header(8'd3, 8'd1, 16'h4142, 8'h00);
      for (int i = 0; i < 100; i++) exp_q.push_back({8'(i), 8'(i)});
      send_sync();
      send_byte(8'h07);
      for (int i = 0; i < 100; i++) send_byte(8'(i));
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_done", done, 1);
      check("abort_status", status, 7);
      check("abort_busy", busy, 0);
      check("abort_addr", buf_addr, 100);
      for (int i = 100; i < 105; i++) send_byte(8'(i));
      check("abort_addr_held", buf_addr, 100);
      check("abort_done_cnt", done_cnt - base, 1);
      check("abort_q_empty", exp_q.size(), 0);

      // reset in the middle of the data block
      do_req(8'd1, 5'd3, 16'h4142, 1'b0);
      send_header(8'd3, 8'd1, 16'h4142, 8'h00);
      for (int i = 0; i < 10; i++) exp_q.push_back({8'(i), 8'(i)});
      send_sync();
      send_byte(8'h07);
      for (int i = 0; i < 10; i++) send_byte(8'(i));
      base = done_cnt;
      reset = 1'b1;
      tick();
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_status", status, 0);
      check("mid_rst_addr", buf_addr, 0);
      check("mid_rst_hdr_id", hdr_id, 0);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) send_byte(8'(i));
      check("mid_rst_no_done", done_cnt - base, 0);
      check("mid_rst_q_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
